// File: rtl/pc_fetch.sv
// pc_fetch: next-PC generator with a decoupled req/ack instruction-fetch port.
//
// Holds the current fetch PC, issues fetches while BUSY, and registers each
// returned instruction toward decode. Branch/jump/JR/COP0 redirects are
// resolved against ex_pc. A redirect that arrives while a fetch is
// outstanding is parked in pend_addr; the stale fetch is squashed on its ack.
//
// Ports:
//   clk, rest            clock, synchronous active-high reset
//   stall                decode back-pressure, blocks issue of new fetches
//   op_valid, pc_op      redirect opcode and its qualifier
//   zero, great          comparator flags for conditional branches
//   ex_pc, im1, im2      resolving PC, branch offset, jump index
//   j_reg, cop_addr      JR target, COP0 exception/eret target
//   if_req, if_addr      fetch request and address (held until ack)
//   if_ack, if_rdata     fetch completion and instruction word
//   id_valid, id_instr   one-cycle delivery pulse and registered instruction
//   id_pc, rt_addr       PC of id_instr and its link address
//
// state | meaning
// IDLE  | no fetch outstanding; waits for !stall to issue
// BUSY  | fetch at pc_r outstanding; if_req held high until if_ack
module pc_fetch #(
  parameter int                  ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]   RESET_ADDR = 32'h8000_0200,
  parameter int                  IM1_W      = 16,
  parameter int                  IM2_W      = 26,
  parameter int                  ALIGN      = 2
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              stall,
  input  logic              op_valid,
  input  logic [3:0]        pc_op,
  input  logic              zero,
  input  logic              great,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [IM1_W-1:0]  im1,
  input  logic [IM2_W-1:0]  im2,
  input  logic [ADDR_W-1:0] j_reg,
  input  logic [ADDR_W-1:0] cop_addr,
  output logic              if_req,
  output logic [ADDR_W-1:0] if_addr,
  input  logic              if_ack,
  input  logic [31:0]       if_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] rt_addr
);

  localparam logic [3:0] PC_OP_NONE  = 4'd0;
  localparam logic [3:0] PC_OP_BZ    = 4'd1;
  localparam logic [3:0] PC_OP_BNZ   = 4'd2;
  localparam logic [3:0] PC_OP_BG    = 4'd3;
  localparam logic [3:0] PC_OP_BNG   = 4'd4;
  localparam logic [3:0] PC_OP_BGZ   = 4'd5;
  localparam logic [3:0] PC_OP_BNGNZ = 4'd6;
  localparam logic [3:0] PC_OP_J     = 4'd7;
  localparam logic [3:0] PC_OP_JR    = 4'd8;
  localparam logic [3:0] PC_OP_COP0  = 4'd9;

  localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1} << ALIGN;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc_r;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;

  logic              br_hit;
  logic              taken;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] tgt;

  assign seq_pc  = ex_pc + PC_INC;
  assign off_ext = {{(ADDR_W-IM1_W){im1[IM1_W-1]}}, im1};
  assign br_tgt  = seq_pc + (off_ext << ALIGN);
  // J keeps the region bits of the sequential PC and replaces the rest.
  assign j_tgt   = {seq_pc[ADDR_W-1:IM2_W+ALIGN], im2, {ALIGN{1'b0}}};

  always_comb begin
    br_hit = 1'b0;
    case (pc_op)
      PC_OP_BZ:    br_hit = zero;
      PC_OP_BNZ:   br_hit = !zero;
      PC_OP_BG:    br_hit = great;
      PC_OP_BNG:   br_hit = !great;
      PC_OP_BGZ:   br_hit = zero | great;
      PC_OP_BNGNZ: br_hit = !zero & !great;
      default:     br_hit = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    tgt   = pc_r;
    if (op_valid) begin
      if (br_hit) begin
        taken = 1'b1;
        tgt   = br_tgt;
      end else if (pc_op == PC_OP_J) begin
        taken = 1'b1;
        tgt   = j_tgt;
      end else if (pc_op == PC_OP_JR) begin
        taken = 1'b1;
        tgt   = j_reg;
      end else if (pc_op == PC_OP_COP0) begin
        taken = 1'b1;
        tgt   = cop_addr;
      end else if (pc_op == PC_OP_NONE) begin
        taken = 1'b0;
      end
    end
  end

  assign if_addr = pc_r;
  assign rt_addr = id_pc + PC_INC;

  always_ff @(posedge clk) begin
    if (rest) begin
      state     <= IDLE;
      pc_r      <= RESET_ADDR;
      pend_v    <= 1'b0;
      pend_addr <= '0;
      if_req    <= 1'b0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= RESET_ADDR;
    end else begin
      id_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (taken) pc_r <= tgt;
          if (!stall) begin
            state  <= BUSY;
            if_req <= 1'b1;
          end
        end
        BUSY: begin
          if (!if_ack) begin
            // Latest redirect wins; pc_r stays put so if_addr is stable.
            if (taken) begin
              pend_v    <= 1'b1;
              pend_addr <= tgt;
            end
          end else begin
            if (taken)       pc_r <= tgt;
            else if (pend_v) pc_r <= pend_addr;
            else             pc_r <= pc_r + PC_INC;
            // A fetch overtaken by any redirect is from the wrong path.
            if (!pend_v && !taken) begin
              id_valid <= 1'b1;
              id_instr <= if_rdata;
              id_pc    <= pc_r;
            end
            pend_v <= 1'b0;
            if (stall) begin
              state  <= IDLE;
              if_req <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          if_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
